// File: rtl/w_row_buf.sv
// Weight-row buffer: packs a narrow word stream into Q*N-bit rows and serves StMM row reads.
// Latency: W_data is registered, one cycle after W_addr; a row commits on the edge that accepts its last word.
// Backpressure: ld_ready is high throughout LOAD and accepts one word per cycle; load_start overrides a same-cycle word.
module w_row_buf #(
    parameter int N      = 176,
    parameter int P      = 704,
    parameter int Q      = 8,
    parameter int WORD_W = 32,
    localparam int ROW_W     = Q * N,
    localparam int ROW_WORDS = ROW_W / WORD_W,
    localparam int AW        = $clog2(P)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     W_addr,
    output logic [ROW_W-1:0]  W_data,
    input  logic              load_start,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              load_done,
    output logic              loaded
);

    localparam int WCW = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
    localparam logic [WCW-1:0] WORD_LAST = WCW'(ROW_WORDS - 1);
    localparam logic [AW-1:0]  ROW_LAST  = AW'(P - 1);
    localparam logic [AW:0]    P_EXT     = (AW + 1)'(P);

    // A row must be an exact number of load words; anything else is a build error.
    if (ROW_W % WORD_W != 0) begin : g_bad_word_width
        $error("w_row_buf: Q*N must be a multiple of WORD_W");
    end

    typedef enum logic {IDLE, LOAD} state_t;

    state_t             state_q, state_d;
    logic [WCW-1:0]     word_cnt;
    logic [AW-1:0]      row_cnt;
    logic [ROW_W-1:0]   pack_q;
    logic [ROW_W-1:0]   row_next;
    logic               accept;
    logic               commit;
    logic               finish;

    logic [ROW_W-1:0]   mem [P];

    // Next state, handshake decode and the row being assembled with the current word merged in.
    always_comb begin
        state_d  = state_q;
        ld_ready = (state_q == LOAD);
        accept   = (state_q == LOAD) && ld_valid && !load_start;
        commit   = accept && (word_cnt == WORD_LAST);
        finish   = commit && (row_cnt == ROW_LAST);
        row_next = pack_q;
        for (int k = 0; k < ROW_WORDS; k++) begin
            if (word_cnt == WCW'(k)) begin
                row_next[k*WORD_W +: WORD_W] = ld_data;
            end
        end
        // A restart always wins over finishing the last row.
        if (load_start) begin
            state_d = LOAD;
        end else if (finish) begin
            state_d = IDLE;
        end
    end

    // State, counters, pack register and the load status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            word_cnt  <= '0;
            row_cnt   <= '0;
            pack_q    <= '0;
            load_done <= 1'b0;
            loaded    <= 1'b0;
        end else begin
            state_q   <= state_d;
            load_done <= finish;
            if (load_start) begin
                word_cnt <= '0;
                row_cnt  <= '0;
                pack_q   <= '0;
                loaded   <= 1'b0;
            end else if (commit) begin
                word_cnt <= '0;
                pack_q   <= '0;
                if (finish) begin
                    row_cnt <= '0;
                    loaded  <= 1'b1;
                end else begin
                    row_cnt <= row_cnt + 1'b1;
                end
            end else if (accept) begin
                word_cnt <= word_cnt + 1'b1;
                pack_q   <= row_next;
            end
        end
    end

    // Row storage: whole-row write on commit, no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (rst_n && commit) begin
            mem[row_cnt] <= row_next;
        end
    end

    // Registered read; a same-cycle commit to the addressed row returns the old contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            W_data <= '0;
        end else if ({1'b0, W_addr} < P_EXT) begin
            W_data <= mem[W_addr];
        end else begin
            W_data <= '0;
        end
    end

endmodule

// File: tb/tb_w_row_buf.sv
// Testbench for w_row_buf: random and directed load/read traffic against a row-level reference model.
// Latency: expectations are queued per cycle and compared one clock later by an independent monitor.
// Backpressure: ld_ready is checked against the model's notion of whether a load is in progress.
module tb_w_row_buf;

    localparam int N      = 4;
    localparam int P      = 6;
    localparam int Q      = 8;
    localparam int WORD_W = 16;
    localparam int ROW_W  = Q * N;
    localparam int RWORDS = ROW_W / WORD_W;
    localparam int AW     = $clog2(P);
    localparam int BEATS  = P * RWORDS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [AW-1:0]     W_addr = '0;
    logic [ROW_W-1:0]  W_data;
    logic              load_start = 1'b0;
    logic [WORD_W-1:0] ld_data = '0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic              load_done;
    logic              loaded;

    always #5 clk = ~clk;

    w_row_buf #(.N(N), .P(P), .Q(Q), .WORD_W(WORD_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .W_addr     (W_addr),
        .W_data     (W_data),
        .load_start (load_start),
        .ld_data    (ld_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .load_done  (load_done),
        .loaded     (loaded)
    );

    typedef struct {
        logic [ROW_W-1:0] rd;
        bit               rd_known;
        bit               done;
        bit               ld;
        bit               rdy;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: rows as whole words, a beat counter per load, and load status flags.
    logic [ROW_W-1:0]  ref_mem [P];
    bit                ref_known [P];
    bit                m_load = 0;
    bit                m_loaded = 0;
    int                m_beats = 0;
    logic [WORD_W-1:0] m_words[$];

    task automatic step(input bit ls, input bit v, input logic [WORD_W-1:0] d,
                        input int a, input bit rst);
        exp_t e;
        logic [ROW_W-1:0] row;
        int r;
        @(negedge clk);
        rst_n      = !rst;
        load_start = ls;
        ld_valid   = v;
        ld_data    = d;
        W_addr     = AW'(a);
        e.rd       = '0;
        e.rd_known = 1;
        e.done     = 0;
        if (rst) begin
            m_load = 0; m_beats = 0; m_loaded = 0; m_words.delete();
        end else begin
            if (a < P) begin
                e.rd = ref_mem[a];
                e.rd_known = ref_known[a];
            end
            if (ls) begin
                m_load = 1; m_beats = 0; m_loaded = 0; m_words.delete();
            end else if (m_load && v) begin
                m_words.push_back(d);
                m_beats++;
                if (m_words.size() == RWORDS) begin
                    row = '0;
                    for (int k = 0; k < RWORDS; k++) row[k*WORD_W +: WORD_W] = m_words[k];
                    r = (m_beats - 1) / RWORDS;
                    ref_mem[r] = row;
                    ref_known[r] = 1;
                    m_words.delete();
                    if (m_beats == BEATS) begin
                        e.done = 1; m_loaded = 1; m_load = 0;
                    end
                end
            end
        end
        e.ld  = m_loaded;
        e.rdy = m_load;
        q.push_back(e);
    endtask

    // Monitor: one clock after each issued cycle, compare every output with the queued expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.rd_known) begin
                checks++;
                if (W_data !== e.rd) begin
                    errors++;
                    $display("FAIL W_data t=%0t got %h expected %h", $time, W_data, e.rd);
                end
            end
            checks++;
            if (load_done !== e.done) begin
                errors++;
                $display("FAIL load_done t=%0t got %b expected %b", $time, load_done, e.done);
            end
            checks++;
            if (loaded !== e.ld) begin
                errors++;
                $display("FAIL loaded t=%0t got %b expected %b", $time, loaded, e.ld);
            end
            checks++;
            if (ld_ready !== e.rdy) begin
                errors++;
                $display("FAIL ld_ready t=%0t got %b expected %b", $time, ld_ready, e.rdy);
            end
        end
    end

    task automatic full_load(input logic [WORD_W-1:0] base, input bit bubbles, input int addr);
        int i;
        step(1, 0, '0, addr < 0 ? $urandom_range(0, 7) : addr, 0);
        i = 0;
        while (i < BEATS) begin
            if (bubbles && (i % 2 == 1) && ld_valid) begin
                step(0, 0, 16'hdead, addr < 0 ? $urandom_range(0, 7) : addr, 0);
            end else begin
                step(0, 1, base + WORD_W'(i), addr < 0 ? $urandom_range(0, 7) : addr, 0);
                i++;
            end
        end
    endtask

    task automatic read_all();
        for (int r = 0; r < 8; r++) step(0, 0, '0, r, 0);
    endtask

    initial begin
        for (int r = 0; r < P; r++) ref_known[r] = 0;

        // Reset
        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 7, 1);
        step(0, 0, '0, 7, 0);

        // Back-to-back full load with beat-index data, then read every address incl. 6 and 7
        full_load(16'h0000, 0, -1);
        step(0, 0, '0, 2, 0);
        read_all();

        // Same load with bubbles
        full_load(16'h0000, 1, -1);
        read_all();

        // Restart after 5 beats, then a complete load of 0x100+i
        step(1, 0, '0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 16'h0f00 + 16'(i), 0, 0);
        full_load(16'h0100, 0, 0);
        read_all();

        // Collision: hold W_addr=3 while row 3 commits
        full_load(16'h0300, 0, 3);
        step(0, 0, '0, 3, 0);

        // load_start coincident with the final beat, then a normal load
        step(1, 0, '0, 1, 0);
        for (int i = 0; i < BEATS - 1; i++) step(0, 1, 16'h0500 + 16'(i), 5, 0);
        step(1, 1, 16'h050b, 5, 0);
        step(0, 0, '0, 5, 0);
        full_load(16'h0600, 0, -1);
        read_all();

        // Reset after 7 beats, then a fresh load
        step(1, 0, '0, 4, 0);
        for (int i = 0; i < 7; i++) step(0, 1, 16'h0700 + 16'(i), 4, 0);
        step(0, 0, '0, 4, 1);
        step(0, 0, '0, 4, 0);
        full_load(16'h0800, 0, -1);
        read_all();

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 WORD_W'($urandom), $urandom_range(0, 7), ($urandom_range(0, 299) == 0));
        end
        read_all();

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
